// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode type, master FSM states and edge helper
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    TRAIL,
    GAP
  } spi_master_state_e;

  // Edges are numbered from 1 and odd edges lead; Cpha=0 samples on leading edges.
  function automatic logic is_sample_edge(input int unsigned k, input logic cpha);
    return k[0] ^ cpha;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period timer, edge counter and sclk register for the SPI master
module spi_sclk_gen #(
  parameter int  Nbit       = 8,
  parameter bit  Cpol       = 1'b0,
  parameter int  HalfPeriod = 4,
  localparam int HpW        = $clog2(HalfPeriod),
  localparam int EdgeW      = $clog2(2 * Nbit)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             sclk_en_i,
  output logic             tick_o,
  output logic             lead_edge_o,
  output logic             trail_edge_o,
  output logic             last_edge_o,
  output logic [EdgeW-1:0] edge_idx_o,
  output logic             sclk_o
);

  logic [HpW-1:0]   hp_cnt_q, hp_cnt_d;
  logic [EdgeW-1:0] edge_cnt_q, edge_cnt_d;
  logic             sclk_q, sclk_d;
  logic             edge_now;

  assign tick_o       = run_i && (hp_cnt_q == HpW'(HalfPeriod - 1));
  assign edge_now     = tick_o && sclk_en_i;
  assign lead_edge_o  = edge_now && !edge_cnt_q[0];
  assign trail_edge_o = edge_now && edge_cnt_q[0];
  assign last_edge_o  = edge_now && (edge_cnt_q == EdgeW'(2 * Nbit - 1));
  assign edge_idx_o   = edge_cnt_q;
  assign sclk_o       = sclk_q;

  // The edge counter parks on its terminal value through TRAIL/GAP instead of wrapping.
  always_comb begin
    hp_cnt_d   = hp_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    if (!run_i) begin
      hp_cnt_d   = '0;
      edge_cnt_d = '0;
      sclk_d     = Cpol;
    end else begin
      hp_cnt_d = tick_o ? '0 : hp_cnt_q + 1'b1;
      if (edge_now) begin
        sclk_d = ~sclk_q;
        if (!last_edge_o) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hp_cnt_q   <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= Cpol;
    end else begin
      hp_cnt_q   <= hp_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master: frame FSM, shift registers and system-side strobes
module spi_master
  import spi_pkg::*;
#(
  parameter int Nbit       = 8,
  parameter bit Cpol       = 1'b0,
  parameter bit Cpha       = 1'b0,
  parameter int HalfPeriod = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [Nbit-1:0] tx_data,
  output logic            ready,
  output logic            tx_strobe,
  output logic [Nbit-1:0] rx_data,
  output logic            rx_strobe,
  output logic            ss_n,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso
);

  localparam spi_mode_t Mode  = {Cpol, Cpha};
  localparam int        EdgeW = $clog2(2 * Nbit);

  spi_master_state_e state_q, state_d;
  logic [Nbit-1:0]   sh_q, sh_d;
  logic [Nbit-1:0]   rx_sh_q, rx_sh_d;
  logic [Nbit-1:0]   rx_data_q, rx_data_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              ready_q, ready_d;
  logic              tx_strobe_q, tx_strobe_d;
  logic              rx_strobe_q, rx_strobe_d;

  logic             accept;
  logic             tick, lead_edge, trail_edge, last_edge, edge_now;
  logic [EdgeW-1:0] edge_idx;

  assign accept   = start && ready_q;
  assign edge_now = lead_edge || trail_edge;

  spi_sclk_gen #(
    .Nbit       (Nbit),
    .Cpol       (Cpol),
    .HalfPeriod (HalfPeriod)
  ) u_sclk_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (state_q != IDLE),
    .sclk_en_i    ((state_q == SETUP) || (state_q == SHIFT)),
    .tick_o       (tick),
    .lead_edge_o  (lead_edge),
    .trail_edge_o (trail_edge),
    .last_edge_o  (last_edge),
    .edge_idx_o   (edge_idx),
    .sclk_o       (sclk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      ready_q     <= 1'b0;
      tx_strobe_q <= 1'b0;
      rx_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      ready_q     <= ready_d;
      tx_strobe_q <= tx_strobe_d;
      rx_strobe_q <= rx_strobe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = SETUP;
      SETUP:   if (lead_edge) state_d = SHIFT;
      SHIFT:   if (last_edge) state_d = TRAIL;
      TRAIL:   if (tick)      state_d = GAP;
      GAP:     if (tick)      state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_d        = sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    mosi_d      = mosi_q;
    tx_strobe_d = accept;
    rx_strobe_d = 1'b0;
    ready_d     = (state_d == IDLE);
    ss_n_d      = (state_d == IDLE) || (state_d == GAP);
    // With Cpha=0 the MSB is on the wire before the first edge, so the register is pre-shifted.
    if (accept) begin
      rx_sh_d = '0;
      if (Mode.cpha) begin
        sh_d   = tx_data;
        mosi_d = 1'b0;
      end else begin
        sh_d   = tx_data << 1;
        mosi_d = tx_data[Nbit-1];
      end
    end else if (edge_now) begin
      if (is_sample_edge(32'(edge_idx) + 32'd1, Mode.cpha)) begin
        rx_sh_d = {rx_sh_q[Nbit-2:0], miso};
      end else if (!last_edge) begin
        mosi_d = sh_q[Nbit-1];
        sh_d   = sh_q << 1;
      end
    end else if ((state_q == TRAIL) && tick) begin
      rx_data_d   = rx_sh_q;
      rx_strobe_d = 1'b1;
      mosi_d      = 1'b0;
    end
  end

  assign ready     = ready_q;
  assign tx_strobe = tx_strobe_q;
  assign rx_data   = rx_data_q;
  assign rx_strobe = rx_strobe_q;
  assign ss_n      = ss_n_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboarded random bench for spi_master in all four SPI modes
`timescale 1ns/1ps
module tb_spi_master;

  localparam int N      = 8;
  localparam int HP     = 4;
  localparam int PERIOD = 1 + (2 * N + 2) * HP;
  localparam int RX_LAT = (2 * N + 1) * HP;
  localparam int RDY_LAT = (2 * N + 2) * HP;

  logic         clk = 1'b0;
  logic         rst_n, start, miso;
  logic [N-1:0] tx_data, rx_data;
  logic         ready, tx_strobe, rx_strobe, ss_n, sclk, mosi;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic rst_seen = 1'b0;

  logic [N-1:0] slave_q[$], exp_rx[$], exp_mosi[$], hist[$];
  int exp_acc = 0;
  bit b2b_mode = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endfunction

  spi_master #(.Nbit(N), .Cpol(1'b0), .Cpha(1'b0), .HalfPeriod(HP)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .ready(ready), .tx_strobe(tx_strobe), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  // Mode-0 slave: presents MSB at ss_n fall, shifts on falling sclk, samples mosi on rising sclk.
  logic [N-1:0] s_word, s_rcv;
  int s_cnt;
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge ss_n);
      s_word = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
      s_rcv  = '0;
      s_cnt  = 0;
      miso   = s_word[N-1];
      s_word = s_word << 1;
      while (ss_n === 1'b0) begin
        @(sclk or ss_n);
        if (ss_n !== 1'b0) break;
        if (sclk === 1'b1) begin
          s_rcv = {s_rcv[N-2:0], mosi};
          s_cnt++;
        end else begin
          miso   = s_word[N-1];
          s_word = s_word << 1;
        end
      end
      if (s_cnt == N) begin
        if (exp_mosi.size() == 0) fail_evt("unexpected frame at slave");
        else chk("mosi word at slave", s_rcv, exp_mosi.pop_front());
      end
    end
  end

  int t_tx, t_prev, edges, ss_low;
  bit in_frame = 1'b0;
  bit prev_b2b = 1'b0;
  logic sclk_prev, ready_prev;
  always @(negedge clk) begin
    if (!rst_seen) begin
      in_frame = 1'b0;
      prev_b2b = 1'b0;
    end else begin
      if (tx_strobe) begin
        if (exp_acc == 0) fail_evt("unexpected tx_strobe");
        else exp_acc--;
        chk("ready low at tx_strobe", ready, 0);
        if (b2b_mode && prev_b2b) chk("back-to-back period", cyc - t_prev, PERIOD);
        prev_b2b = b2b_mode;
        t_prev   = cyc;
        t_tx     = cyc;
        in_frame = 1'b1;
        edges    = 0;
        ss_low   = 0;
      end
      if (in_frame) begin
        if (sclk !== sclk_prev) edges++;
        if (ss_n === 1'b0) ss_low++;
      end
      if (rx_strobe) begin
        if (exp_rx.size() == 0) fail_evt("unexpected rx_strobe");
        else chk("rx_data", rx_data, exp_rx.pop_front());
        chk("rx_strobe latency", cyc - t_tx, RX_LAT);
        chk("ss_n low cycles", ss_low, RX_LAT);
        chk("sclk edges per frame", edges, 2 * N);
        chk("ss_n high at rx_strobe", ss_n, 1);
        chk("mosi idle at rx_strobe", mosi, 0);
        chk("sclk idle at rx_strobe", sclk, 0);
      end
      if (in_frame && ready && !ready_prev) begin
        chk("ready latency", cyc - t_tx, RDY_LAT);
        in_frame = 1'b0;
      end
    end
    sclk_prev  = sclk;
    ready_prev = ready;
  end

  // Other three modes run in loopback on the same start/tx_data; rx must equal what was sent.
  for (genvar gi = 1; gi < 4; gi++) begin : g_mode
    localparam bit VCpol = ((gi / 2) == 1);
    localparam bit VCpha = ((gi % 2) == 1);
    logic         v_ready, v_txs, v_rxs, v_ss_n, v_sclk, v_mosi;
    logic [N-1:0] v_rx;
    int rx_n = 0;
    int e = 0;
    bit act = 1'b0;
    logic sp;

    spi_master #(.Nbit(N), .Cpol(VCpol), .Cpha(VCpha), .HalfPeriod(HP)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
      .ready(v_ready), .tx_strobe(v_txs), .rx_data(v_rx), .rx_strobe(v_rxs),
      .ss_n(v_ss_n), .sclk(v_sclk), .mosi(v_mosi), .miso(v_mosi)
    );

    always @(negedge clk) begin
      if (!rst_seen) begin
        act = 1'b0;
      end else begin
        if (v_txs) begin
          act = 1'b1;
          e   = 0;
        end
        if (act && (v_sclk !== sp)) e++;
        if (v_rxs) begin
          if (rx_n >= hist.size()) fail_evt($sformatf("mode%0d unexpected rx_strobe", gi));
          else chk($sformatf("mode%0d loopback rx", gi), v_rx, hist[rx_n]);
          rx_n++;
          chk($sformatf("mode%0d sclk edges", gi), e, 2 * N);
          chk($sformatf("mode%0d sclk idle", gi), v_sclk, VCpol);
        end
      end
      sp = v_sclk;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) fail_evt("timeout waiting for ready");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_rx.size() != 0 || ready !== 1'b1) && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (exp_rx.size() != 0 || ready !== 1'b1) fail_evt("timeout waiting for idle");
  endtask

  task automatic send(input logic [N-1:0] tx, input logic [N-1:0] sw, input bit hold);
    wait_ready();
    start   = 1'b1;
    tx_data = tx;
    slave_q.push_back(sw);
    exp_rx.push_back(sw);
    exp_mosi.push_back(tx);
    hist.push_back(tx);
    exp_acc++;
    @(negedge clk);
    if (!hold) start = 1'b0;
    tx_data = N'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset ss_n", ss_n, 1);
    chk("reset sclk", sclk, 0);
    chk("reset mosi", mosi, 0);
    chk("reset ready", ready, 0);
    chk("reset tx_strobe", tx_strobe, 0);
    chk("reset rx_strobe", rx_strobe, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset sclk cpol1", g_mode[2].v_sclk, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after release", ready, 1);

    send(8'hA5, 8'h3C, 1'b0);
    wait_idle();

    send(8'h81, 8'h81, 1'b0);
    send(8'h7E, 8'h7E, 1'b0);
    wait_idle();

    b2b_mode = 1'b1;
    send(8'h01, 8'h01, 1'b1);
    send(8'h02, 8'h02, 1'b1);
    send(8'h03, 8'h03, 1'b0);
    wait_idle();
    b2b_mode = 1'b0;

    send(8'h00, N'($urandom), 1'b0);
    repeat (9) @(negedge clk);
    start   = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    send(8'h5A, 8'h96, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort ss_n", ss_n, 1);
    chk("abort sclk", sclk, 0);
    chk("abort sclk cpol1", g_mode[3].v_sclk, 1);
    chk("abort mosi", mosi, 0);
    chk("abort rx_strobe", rx_strobe, 0);
    chk("abort rx_data", rx_data, 0);
    chk("abort ready", ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after abort", ready, 1);
    exp_rx.delete();
    exp_mosi.delete();
    slave_q.delete();
    void'(hist.pop_back());

    wait_ready();
    start   = 1'b1;
    rst_n   = 1'b0;
    tx_data = 8'h55;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    chk("reset-on-accept ss_n", ss_n, 1);
    chk("reset-on-accept ready", ready, 0);
    @(negedge clk);
    chk("reset-on-accept ready after", ready, 1);

    send(8'hC3, 8'hC3, 1'b0);
    wait_idle();

    for (int i = 0; i < 100; i++) begin
      send(N'($urandom), N'($urandom), 1'b0);
      repeat ($urandom_range(0, 90)) @(negedge clk);
    end
    wait_idle();
    repeat (4) @(negedge clk);

    chk("slave frames left", exp_mosi.size(), 0);
    chk("accepts left", exp_acc, 0);
    chk("mode1 rx count", g_mode[1].rx_n, hist.size());
    chk("mode2 rx count", g_mode[2].rx_n, hist.size());
    chk("mode3 rx count", g_mode[3].rx_n, hist.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
